// File: rtl/mem_pkg.sv
// Shared types and widths for the memory responder slice.
// Contents:
//   mem_state_t - responder controller states (IDLE, WAIT, RESP)
//   WORD_W      - bus/array word width
//   BE_W        - number of byte lanes per word
//   LAT_W       - width of the wait-state counter
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   localparam int WORD_W = 32;
   localparam int BE_W   = 4;
   localparam int LAT_W  = 3;

endpackage

// File: rtl/sram_1p_be.sv
// Single-port synchronous word array with per-byte write enables.
// The read result is registered and holds until the next read.
// Contents are never reset.
// Ports:
//   clk    in   1            clock, rising edge
//   en     in   1            access strobe; one read or write per strobe
//   we     in   1            1 = write the enabled lanes, 0 = read
//   addr   in   AW           word index
//   wdata  in   WORD_W       write data
//   be     in   BE_W         byte-lane write enables
//   rdata  out  WORD_W       registered read data
module sram_1p_be
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter     INIT_FILE   = "",
   localparam int AW         = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [BE_W-1:0]   be,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
   logic [WORD_W-1:0] rdata_q, rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (en && !we) begin
         rdata_d = mem_q[addr];
      end
   end

   always_ff @(posedge clk) begin
      rdata_q <= rdata_d;
   end

   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
               mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the core's unified instruction/data bus.
// It accepts one word request at a time over a valid/ready handshake.
// Each request completes after LATENCY wait states. A one-cycle response
// follows, which carries the read data and an error flag.
// Ports:
//   clk        in   1    clock, rising edge
//   reset      in   1    asynchronous reset, active-low
//   req_valid  in   1    request present
//   req_ready  out  1    responder can accept (high only in IDLE)
//   req_we     in   1    1 = write, 0 = read
//   req_addr   in   32   byte address
//   req_wdata  in   32   write data
//   req_be     in   4    byte enables, bit i -> bits [8i+7:8i]
//   rsp_valid  out  1    response valid, exactly one cycle
//   rsp_rdata  out  32   read data; 0 for writes and errors
//   rsp_err    out  1    misaligned or out-of-range request
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 1,
   parameter     INIT_FILE   = ""
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [WORD_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   input  logic [BE_W-1:0]   req_be,
   output logic              rsp_valid,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam bit HAS_WAIT = (LATENCY > 0);
   localparam logic [LAT_W-1:0] CNT_INIT = HAS_WAIT ? LAT_W'(LATENCY - 1) : '0;

   mem_state_t        state_q, state_d;
   logic [LAT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [WORD_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_rd_q, rsp_rd_d;

   logic              addr_err;
   logic              ram_en;
   logic [WORD_W-1:0] ram_rdata;

   // DEPTH_WORDS is a power of two. Any set bit above the index field
   // therefore means the word index is out of range.
   assign addr_err = (addr_q[1:0] != 2'b00) || (|addr_q[WORD_W-1:AW+2]);

   // Gating with reset keeps ready low while reset is held.
   assign req_ready = reset && (state_q == IDLE);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rd_d    = 1'b0;
      ram_en      = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               be_d    = req_be;
               if (HAS_WAIT) begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            // The array is accessed on the edge leaving RESP. The response
            // flags are registered on that same edge, so the read data and
            // the flags appear together in the following cycle.
            state_d     = IDLE;
            ram_en      = !addr_err;
            rsp_valid_d = 1'b1;
            rsp_err_d   = addr_err;
            rsp_rd_d    = !addr_err && !we_q;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rd_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rd_q    <= rsp_rd_d;
      end
   end

   sram_1p_be #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .INIT_FILE   (INIT_FILE)
   ) u_sram (
      .clk   (clk),
      .en    (ram_en),
      .we    (we_q),
      .addr  (addr_q[AW+1:2]),
      .wdata (wdata_q),
      .be    (be_q),
      .rdata (ram_rdata)
   );

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   // The array output register holds stale data between reads. The read
   // flag forces the output to zero outside read responses.
   assign rsp_rdata = rsp_rd_q ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder. Four instances run with LATENCY 0, 1, 3 and 7.
// They share the clock and reset, and each one is checked against a word-array model.
module tb_mem_responder;

   localparam int ND    = 4;
   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid [ND];
   logic        req_ready [ND];
   logic        req_we    [ND];
   logic [31:0] req_addr  [ND];
   logic [31:0] req_wdata [ND];
   logic [3:0]  req_be    [ND];
   logic        rsp_valid [ND];
   logic [31:0] rsp_rdata [ND];
   logic        rsp_err   [ND];

   for (genvar g = 0; g < ND; g++) begin : g_dut
      mem_responder #(
         .DEPTH_WORDS (DEPTH),
         .LATENCY     ((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 7),
         .INIT_FILE   ("")
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_we    (req_we[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .req_be    (req_be[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_rdata (rsp_rdata[g]),
         .rsp_err   (rsp_err[g])
      );
   end

   function automatic int lat_of(int d);
      case (d)
         0:       return 0;
         1:       return 1;
         2:       return 3;
         default: return 7;
      endcase
   endfunction

   // Reference model: plain word array per instance, plus a flag for
   // words whose full value is known.
   logic [31:0] mdl_mem   [ND][DEPTH];
   bit          mdl_known [ND][DEPTH];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit mdl_err(input logic [31:0] a);
      return ((a % 4) != 0) || ((a / 4) >= DEPTH);
   endfunction

   task automatic mdl_apply(input int d, input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be,
                            output bit err, output logic [31:0] rd, output bit rd_valid);
      int w;
      err = mdl_err(a);
      rd = 32'h0;
      rd_valid = 1'b1;
      if (!err) begin
         w = int'(a / 4);
         if (we) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mdl_mem[d][w][8*b +: 8] = wd[8*b +: 8];
            end
            if (be == 4'hF) mdl_known[d][w] = 1'b1;
         end else begin
            rd = mdl_mem[d][w];
            rd_valid = mdl_known[d][w];
         end
      end
   endtask

   // One isolated request. The response must be sampled at edge accept+L+2.
   // At the negedges this is the (L+1)th one after the accept edge,
   // counting from zero.
   task automatic do_req(input int d, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         input string tag, output logic [31:0] obs_rd);
      bit          err, ck, got;
      logic [31:0] exp_rd;
      int          k, lowc, lat;
      lat = lat_of(d);
      obs_rd = 32'hXXXXXXXX;
      @(negedge clk);
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = a;
      req_wdata[d] = wd;
      req_be[d]    = be;
      k = 0;
      while (!req_ready[d] && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready[d]) begin
         chk({tag, " ready_timeout"}, 32'(req_ready[d]), 32'h1);
         req_valid[d] = 1'b0;
         return;
      end
      mdl_apply(d, we, a, wd, be, err, exp_rd, ck);
      @(negedge clk);
      // The captured copy must be used, so the pins are scrambled here.
      req_valid[d] = 1'b0;
      req_we[d]    = 1'($urandom);
      req_addr[d]  = $urandom;
      req_wdata[d] = $urandom;
      req_be[d]    = 4'($urandom);
      k = 0;
      lowc = 0;
      got = 1'b0;
      while (!got && k < 20) begin
         if (rsp_valid[d]) begin
            got = 1'b1;
         end else begin
            if (!req_ready[d]) lowc++;
            @(negedge clk);
            k++;
         end
      end
      chk({tag, " rsp_valid"}, 32'(got), 32'h1);
      if (got) begin
         obs_rd = rsp_rdata[d];
         chk({tag, " latency"}, 32'(k + 1), 32'(lat + 2));
         chk({tag, " ready_low"}, 32'(lowc), 32'(lat + 1));
         chk({tag, " ready_at_rsp"}, 32'(req_ready[d]), 32'h1);
         chk({tag, " err"}, 32'(rsp_err[d]), 32'(err));
         if (ck) chk({tag, " rdata"}, rsp_rdata[d], exp_rd);
         @(negedge clk);
         chk({tag, " one_cycle"}, 32'(rsp_valid[d]), 32'h0);
      end
   endtask

   // Back-to-back reads with req_valid held high. Edge indices are global
   // negedge counts plus one, meaning the edge that follows a sampled negedge.
   task automatic b2b(input int d, input int nreq);
      int          acc_e[$];
      int          rsp_e[$];
      logic [31:0] exp_q[$];
      logic [31:0] a, e;
      int          t, nacc, lat, lowc;
      bit          pend;
      lat = lat_of(d);
      t = 0;
      nacc = 0;
      lowc = 0;
      pend = 1'b0;
      a = 32'($urandom_range(0, 15)) << 2;
      @(negedge clk);
      req_valid[d] = 1'b1;
      req_we[d]    = 1'b0;
      req_addr[d]  = a;
      req_be[d]    = 4'hF;
      while (rsp_e.size() < nreq && t < 400) begin
         if (rsp_valid[d]) begin
            rsp_e.push_back(t + 1);
            chk($sformatf("b2b%0d ready_at_rsp", d), 32'(req_ready[d]), 32'h1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
            chk($sformatf("b2b%0d rdata", d), rsp_rdata[d], e);
         end
         if (pend) begin
            pend = 1'b0;
            if (nacc == nreq) begin
               req_valid[d] = 1'b0;
            end else begin
               a = 32'($urandom_range(0, 15)) << 2;
               req_addr[d] = a;
            end
         end
         if (req_valid[d] && req_ready[d]) begin
            acc_e.push_back(t + 1);
            exp_q.push_back(mdl_mem[d][a >> 2]);
            nacc++;
            pend = 1'b1;
         end else if (req_valid[d] && nacc > 0 && !req_ready[d]) begin
            lowc++;
         end
         @(negedge clk);
         t++;
      end
      req_valid[d] = 1'b0;
      chk($sformatf("b2b%0d accepts", d), 32'(nacc), 32'(nreq));
      chk($sformatf("b2b%0d responses", d), 32'(rsp_e.size()), 32'(nreq));
      chk($sformatf("b2b%0d ready_low_total", d), 32'(lowc), 32'((nreq - 1) * (lat + 1)));
      for (int i = 0; i < nreq; i++) begin
         if (i < acc_e.size() && i < rsp_e.size()) begin
            chk($sformatf("b2b%0d lat[%0d]", d, i), 32'(rsp_e[i] - acc_e[i]), 32'(lat + 2));
         end
         if (i > 0 && i < acc_e.size()) begin
            chk($sformatf("b2b%0d spacing[%0d]", d, i), 32'(acc_e[i] - acc_e[i-1]), 32'(lat + 2));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, a, wd;
      logic [3:0]  be;
      logic        we;
      int          r, w;

      for (int d = 0; d < ND; d++) begin
         req_valid[d] = 1'b0;
         req_we[d]    = 1'b0;
         req_addr[d]  = 32'h0;
         req_wdata[d] = 32'h0;
         req_be[d]    = 4'h0;
         for (int i = 0; i < DEPTH; i++) mdl_known[d][i] = 1'b0;
      end

      // Reset held for three cycles.
      #2 reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int d = 0; d < ND; d++) begin
            chk($sformatf("rst%0d ready", d), 32'(req_ready[d]), 32'h0);
            chk($sformatf("rst%0d rsp_valid", d), 32'(rsp_valid[d]), 32'h0);
            chk($sformatf("rst%0d rdata", d), rsp_rdata[d], 32'h0);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         chk($sformatf("rel%0d ready", d), 32'(req_ready[d]), 32'h1);
      end

      // Write then read, LATENCY=1.
      do_req(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr10", rd);
      chk("wr10 rdata_zero", rd, 32'h0);
      do_req(1, 1'b0, 32'h10, 32'h0, 4'hF, "rd10", rd);
      chk("rd10 value", rd, 32'hDEADBEEF);

      // Byte lanes.
      do_req(1, 1'b1, 32'h10, 32'h00000055, 4'b0001, "wr_lane0", rd);
      do_req(1, 1'b0, 32'h10, 32'h0, 4'hF, "rd_lane0", rd);
      chk("rd_lane0 value", rd, 32'hDEADBE55);
      do_req(1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, "wr_be0", rd);
      do_req(1, 1'b0, 32'h10, 32'h0, 4'hF, "rd_be0", rd);
      chk("rd_be0 value", rd, 32'hDEADBE55);

      // Errors: misaligned read, out-of-range write.
      do_req(1, 1'b1, 32'h0, 32'h12345678, 4'hF, "wr0", rd);
      do_req(1, 1'b0, 32'h13, 32'h0, 4'hF, "rd13", rd);
      chk("rd13 rdata_zero", rd, 32'h0);
      do_req(1, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, "wr1000", rd);
      do_req(1, 1'b0, 32'h0, 32'h0, 4'hF, "rd0_after_err", rd);
      chk("rd0_after_err value", rd, 32'h12345678);

      // Fill words 0..15 and the top word of every instance with known data.
      for (int d = 0; d < ND; d++) begin
         for (int i = 0; i < 17; i++) begin
            w = (i == 16) ? DEPTH - 1 : i;
            do_req(d, 1'b1, 32'(w) << 2, $urandom, 4'hF, $sformatf("fill%0d_%0d", d, w), rd);
         end
      end

      // Latency sweep with back-to-back reads.
      b2b(0, 4);
      b2b(3, 3);

      // Reset during WAIT drops a pending write (LATENCY=3).
      do_req(2, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, "wr20", rd);
      @(negedge clk);
      req_valid[2] = 1'b1;
      req_we[2]    = 1'b1;
      req_addr[2]  = 32'h20;
      req_wdata[2] = 32'h11111111;
      req_be[2]    = 4'hF;
      chk("midrst ready_before", 32'(req_ready[2]), 32'h1);
      @(negedge clk);
      req_valid[2] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("midrst rsp_in_reset", 32'(rsp_valid[2]), 32'h0);
         chk("midrst ready_in_reset", 32'(req_ready[2]), 32'h0);
      end
      reset = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("midrst no_rsp", 32'(rsp_valid[2]), 32'h0);
      end
      do_req(2, 1'b0, 32'h20, 32'h0, 4'hF, "rd20_after_rst", rd);
      chk("rd20_after_rst value", rd, 32'hA5A5A5A5);

      // Randomised traffic on every instance.
      for (int d = 0; d < ND; d++) begin
         for (int i = 0; i < 25; i++) begin
            r = $urandom_range(0, 9);
            w = ($urandom_range(0, 7) == 0) ? DEPTH - 1 : $urandom_range(0, 15);
            if (r < 7)       a = 32'(w) << 2;
            else if (r == 7) a = (32'(w) << 2) + 32'($urandom_range(1, 3));
            else             a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
            we = 1'($urandom);
            wd = $urandom;
            be = 4'($urandom);
            do_req(d, we, a, wd, be, $sformatf("rnd%0d_%0d", d, i), rd);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
